upstream_order_scheduler: RTL and testbench
===========================================

Name: upstream_order_scheduler

Overview:
Shares the single upstream cache/risk datapath between NUM_PORTS order-entry requesters. It arbitrates round-robin and sequences each granted request through the cache: read the client line, run the risk check, write back on pass, then respond. The block sits between the order-entry front ends and dm_cache_fsm_upstream. It replaces the free-running combinational request drive with a strict one-request-in-flight read-check-write sequence.

Parameters:
NUM_PORTS, 4, number of order requesters (2..8)
TIMEOUT, 64, cycles to wait for cache_res_ready before aborting a request
PW, $clog2(NUM_PORTS), port index width (derived, not overridable)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_valid  in  NUM_PORTS  per-port request pending
req_ready  out  NUM_PORTS  one-hot, 1-cycle pulse: request captured
req_client_id  in  NUM_PORTS*5  per-port client index, port p at [5p+4:5p]
req_amount  in  NUM_PORTS*16  per-port order amount or new max
req_new_max  in  NUM_PORTS  1 = request is a max-to-trade update, not an order
cancelled_orders  in  16  cancelled total for the active client, sampled in CHECK
cache_req_valid  out  1  cache request strobe (held until cache_res_ready)
cache_req_rw  out  1  0 = read, 1 = write
cache_req_index  out  32  {18'b0, 5-bit client_id zero-extended to 10 bits, 4'b0}
cache_req_data  out  32  write data {max[15:0], acc[15:0]}
cache_res_ready  in  1  cache completed current request
cache_res_data  in  32  read data {max[31:16], acc[15:0]}
rsp_valid  out  1  1-cycle response pulse
rsp_port  out  PW  port the response belongs to
rsp_accept  out  1  1 = order passed, or max updated
rsp_timeout  out  1  1 = aborted on cache timeout (rsp_accept=0)
busy  out  1  state != IDLE

Behaviour:
- Reset (async, any state): state=IDLE, rr_ptr=0, timer=0, and all outputs 0. An in-flight cache request is dropped; the cache is not re-synchronised by this block.
- States: IDLE, RD, CHECK, WR, RSP.
- IDLE:
  - If any req_valid, grant the first set bit at or after rr_ptr (wrapping).
  - Pulse req_ready[g] for one cycle and capture client_id, amount and new_max into working registers.
  - Set rr_ptr=(g+1) mod NUM_PORTS and go to RD.
  - No grant when no request is valid; rr_ptr is unchanged.
- RD:
  - cache_req_valid=1, rw=0, index from the captured client.
  - On cache_res_ready, latch cache_res_data into line_q and go to CHECK.
- CHECK (exactly 1 cycle), with max=line_q[31:16] and acc=line_q[15:0]:
  - new_max=1: wdata={amount, acc}, pass=1.
  - new_max=0:
    - result=acc+(~cancelled+1)+amount, 16-bit wrap.
    - pass = $signed({1'b0,max}) > $signed(result).
    - wdata={max, acc+amount}, 16-bit wrap.
  - pass goes to WR; fail goes to RSP with accept=0.
- WR: cache_req_valid=1, rw=1, data=wdata. On cache_res_ready go to RSP with accept=1.
- RSP: rsp_valid=1 for one cycle with the captured port, then IDLE. Next grant is earliest the cycle after RSP.
- Timeout:
  - timer clears on entry to RD and to WR, and increments each cycle waiting.
  - At timer==TIMEOUT-1 without ready: drop cache_req_valid, go to RSP with accept=0, timeout=1, and perform no write.
- Latency, ready asserted in the same cycle as the request:
  - Read+write path: grant→rsp_valid is 5 cycles (IDLE, RD, CHECK, WR, RSP).
  - Reject path: 4 cycles.
- Simultaneous events:
  - req_valid changes on other ports during a sequence are ignored until IDLE.
  - Requester must hold valid and its payload until req_ready.
  - cache_res_ready outside RD/WR is ignored.
- Exactly one of RD/WR issues cache_req_valid at a time; never rw=1 without a preceding pass in CHECK.

Decomposition:
- Shared package upstream_pkg: state enum, field constants (MAX_MSB=31, MAX_LSB=16, ACC_MSB=15), client-id width 5, amount width 16, and function risk_pass(max, acc, cancelled, amount).
- One sub-module: rr_arbiter (NUM_PORTS req, rr_ptr in, one-hot grant + index out, purely combinational).

Test Plan:
- Port 0 order, client 3, amount 10; line {max=100, acc=20}; cancelled=5; ready next cycle → write {100, 30}, rsp port0 accept=1, 5 cycles grant→rsp.
- Port 1 order, amount 90; line {100, 20}; cancelled 5 (result 105) → no rw=1 issued, rsp accept=0, 4 cycles.
- Port 2 new_max, amount 500; line {100, 20} → write {500, 20}, accept=1, regardless of cancelled.
- All 4 ports valid continuously → grants 0,1,2,3,0 in order; each req_ready one pulse; rr_ptr wraps 3→0.
- Cache never asserts ready, TIMEOUT=64 → cache_req_valid drops after 64 RD cycles, rsp timeout=1 accept=0, next request served.
- rst asserted mid-WR → all outputs 0 asynchronously (same cycle), state IDLE; after release, a pending port 0 request is granted first.

Source files
------------

// File: rtl/upstream_pkg.sv
// Shared types, line-field constants and the risk check used by the upstream order scheduler.
package upstream_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_CHECK = 3'd2,
        S_WR    = 3'd3,
        S_RSP   = 3'd4
    } state_e;

    localparam int MAX_MSB = 31;
    localparam int MAX_LSB = 16;
    localparam int ACC_MSB = 15;
    localparam int CID_W   = 5;
    localparam int AMT_W   = 16;

    // Order passes when the line's max, taken as a non-negative value, strictly exceeds
    // the signed 16-bit exposure acc - cancelled + amount.
    function automatic logic risk_pass(input logic [AMT_W-1:0] max_v,
                                       input logic [AMT_W-1:0] acc_v,
                                       input logic [AMT_W-1:0] cancelled_v,
                                       input logic [AMT_W-1:0] amount_v);
        logic [AMT_W-1:0] result;
        result = acc_v + (~cancelled_v + 16'd1) + amount_v;
        return $signed({1'b0, max_v}) > $signed({result[AMT_W-1], result});
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr, wrapping.
module rr_arbiter #(
    parameter  int NUM_PORTS = 4,
    localparam int PW        = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PW-1:0]        rr_ptr,
    output logic [NUM_PORTS-1:0] grant,
    output logic [PW-1:0]        grant_idx,
    output logic                 grant_valid
);

    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant[idx]  = 1'b1;
                grant_idx   = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/upstream_order_scheduler.sv
// Round-robin front end for the upstream cache/risk path: one request in flight,
// sequenced as read line, risk check, write back on pass, respond.
module upstream_order_scheduler
    import upstream_pkg::*;
#(
    parameter  int NUM_PORTS = 4,
    parameter  int TIMEOUT   = 64,
    localparam int PW        = $clog2(NUM_PORTS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_PORTS-1:0]       req_valid,
    output logic [NUM_PORTS-1:0]       req_ready,
    input  logic [NUM_PORTS*5-1:0]     req_client_id,
    input  logic [NUM_PORTS*16-1:0]    req_amount,
    input  logic [NUM_PORTS-1:0]       req_new_max,
    input  logic [15:0]                cancelled_orders,
    output logic                       cache_req_valid,
    output logic                       cache_req_rw,
    output logic [31:0]                cache_req_index,
    output logic [31:0]                cache_req_data,
    input  logic                       cache_res_ready,
    input  logic [31:0]                cache_res_data,
    output logic                       rsp_valid,
    output logic [PW-1:0]              rsp_port,
    output logic                       rsp_accept,
    output logic                       rsp_timeout,
    output logic                       busy
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [PW-1:0]    port_q, port_d;
    logic [CID_W-1:0] client_q, client_d;
    logic [AMT_W-1:0] amount_q, amount_d;
    logic             new_max_q, new_max_d;
    logic [31:0]      line_q, line_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             accept_q, accept_d;
    logic             timeout_q, timeout_d;

    logic [NUM_PORTS-1:0] grant;
    logic [PW-1:0]        grant_idx;
    logic                 grant_valid;

    rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
        .req         (req_valid),
        .rr_ptr      (rr_ptr_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        logic [AMT_W-1:0] max_v;
        logic [AMT_W-1:0] acc_v;
        logic             pass;
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        timer_d   = timer_q;
        port_d    = port_q;
        client_d  = client_q;
        amount_d  = amount_q;
        new_max_d = new_max_q;
        line_d    = line_q;
        wdata_d   = wdata_q;
        accept_d  = accept_q;
        timeout_d = timeout_q;
        max_v     = line_q[MAX_MSB:MAX_LSB];
        acc_v     = line_q[ACC_MSB:0];
        pass      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    port_d = grant_idx;
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        if (grant[p]) begin
                            client_d  = req_client_id[p*CID_W +: CID_W];
                            amount_d  = req_amount[p*AMT_W +: AMT_W];
                            new_max_d = req_new_max[p];
                        end
                    end
                    rr_ptr_d  = (grant_idx == PW'(NUM_PORTS - 1)) ? '0 : grant_idx + PW'(1);
                    timer_d   = '0;
                    accept_d  = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = S_RD;
                end
            end
            S_RD: begin
                if (cache_res_ready) begin
                    line_d  = cache_res_data;
                    state_d = S_CHECK;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_RSP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_CHECK: begin
                if (new_max_q) begin
                    wdata_d = {amount_q, acc_v};
                    pass    = 1'b1;
                end else begin
                    wdata_d = {max_v, acc_v + amount_q};
                    pass    = risk_pass(max_v, acc_v, cancelled_orders, amount_q);
                end
                if (pass) begin
                    timer_d = '0;
                    state_d = S_WR;
                end else begin
                    state_d = S_RSP;
                end
            end
            S_WR: begin
                if (cache_res_ready) begin
                    accept_d = 1'b1;
                    state_d  = S_RSP;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_RSP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_RSP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            timer_q   <= '0;
            port_q    <= '0;
            client_q  <= '0;
            amount_q  <= '0;
            new_max_q <= 1'b0;
            line_q    <= '0;
            wdata_q   <= '0;
            accept_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            timer_q   <= timer_d;
            port_q    <= port_d;
            client_q  <= client_d;
            amount_q  <= amount_d;
            new_max_q <= new_max_d;
            line_q    <= line_d;
            wdata_q   <= wdata_d;
            accept_q  <= accept_d;
            timeout_q <= timeout_d;
        end
    end

    // The grant is combinational in IDLE, so it is masked while reset is held.
    assign req_ready       = (state_q == S_IDLE && !rst) ? grant : '0;
    assign cache_req_valid = (state_q == S_RD) || (state_q == S_WR);
    assign cache_req_rw    = (state_q == S_WR);
    assign cache_req_index = {18'b0, 5'b0, client_q, 4'b0};
    assign cache_req_data  = wdata_q;
    assign rsp_valid       = (state_q == S_RSP);
    assign rsp_port        = port_q;
    assign rsp_accept      = rsp_valid & accept_q;
    assign rsp_timeout     = rsp_valid & timeout_q;
    assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_upstream_order_scheduler.sv
// Bench for upstream_order_scheduler: directed vector table, corner sequences and
// randomized transactions checked against a behavioural model.
module tb_upstream_order_scheduler;

    localparam int NP      = 4;
    localparam int TIMEOUT = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NP-1:0]   req_valid = '0;
    logic [NP-1:0]   req_ready;
    logic [NP*5-1:0] req_client_id = '0;
    logic [NP*16-1:0] req_amount = '0;
    logic [NP-1:0]   req_new_max = '0;
    logic [15:0]     cancelled_orders = '0;
    logic            cache_req_valid;
    logic            cache_req_rw;
    logic [31:0]     cache_req_index;
    logic [31:0]     cache_req_data;
    logic            cache_res_ready = 1'b0;
    logic [31:0]     cache_res_data = '0;
    logic            rsp_valid;
    logic [1:0]      rsp_port;
    logic            rsp_accept;
    logic            rsp_timeout;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [4:0] exp_q[$];

    upstream_order_scheduler #(.NUM_PORTS(NP), .TIMEOUT(TIMEOUT)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_client_id    (req_client_id),
        .req_amount       (req_amount),
        .req_new_max      (req_new_max),
        .cancelled_orders (cancelled_orders),
        .cache_req_valid  (cache_req_valid),
        .cache_req_rw     (cache_req_rw),
        .cache_req_index  (cache_req_index),
        .cache_req_data   (cache_req_data),
        .cache_res_ready  (cache_res_ready),
        .cache_res_data   (cache_res_data),
        .rsp_valid        (rsp_valid),
        .rsp_port         (rsp_port),
        .rsp_accept       (rsp_accept),
        .rsp_timeout      (rsp_timeout),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string name);
        chk(name, 64'({req_ready, cache_req_valid, cache_req_rw, rsp_valid, rsp_port,
                       rsp_accept, rsp_timeout, busy}), 64'd0);
        chk({name, "_bus"}, {cache_req_index, cache_req_data}, 64'd0);
    endtask

    task automatic do_reset();
        req_valid       = '0;
        cache_res_ready = 1'b0;
        rst             = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk_outputs_zero("reset_outputs");
        rst = 1'b0;
    endtask

    // Behavioural model: decision, write data and grant-to-response cycle count (inclusive).
    function automatic void ref_model(input logic [15:0] mx, input logic [15:0] ac,
                                      input logic [15:0] canc, input logic [15:0] amt,
                                      input logic nm, input int rd_lat, input int wr_lat,
                                      output logic acc_o, output logic to_o, output logic wr_o,
                                      output logic [31:0] wd, output int cyc);
        int res, sres;
        bit pass;
        res  = (int'(ac) - int'(canc) + int'(amt)) & 'hFFFF;
        sres = (res >= 32768) ? res - 65536 : res;
        pass = nm ? 1'b1 : (int'(mx) > sres);
        wd   = nm ? {amt, ac} : {mx, 16'((int'(ac) + int'(amt)) & 'hFFFF)};
        if (rd_lat >= TIMEOUT) begin
            acc_o = 0; to_o = 1; wr_o = 0; cyc = TIMEOUT + 2;
        end else if (!pass) begin
            acc_o = 0; to_o = 0; wr_o = 0; cyc = rd_lat + 4;
        end else if (wr_lat >= TIMEOUT) begin
            acc_o = 0; to_o = 1; wr_o = 1; cyc = rd_lat + TIMEOUT + 4;
        end else begin
            acc_o = 1; to_o = 0; wr_o = 1; cyc = rd_lat + wr_lat + 5;
        end
    endfunction

    // Drives one request on port p and plays the cache with the given read/write latencies.
    task automatic run_txn(input int p, input logic [4:0] cid, input logic [15:0] amt,
                           input logic nm, input logic [15:0] mx, input logic [15:0] ac,
                           input logic [15:0] canc, input int rd_lat, input int wr_lat,
                           input bit noise, input logic exp_acc, input logic exp_to,
                           input logic exp_wr, input logic [31:0] exp_wd, input int exp_cyc);
        int k, rd_n, wr_n;
        bit done, idx_checked, wr_seen;
        logic [31:0] wd;
        logic [4:0] exp_r;
        k = 0; rd_n = 0; wr_n = 0; done = 0; idx_checked = 0; wr_seen = 0; wd = '0;
        req_valid                 = '0;
        req_valid[p]              = 1'b1;
        req_client_id[p*5 +: 5]   = cid;
        req_amount[p*16 +: 16]    = amt;
        req_new_max[p]            = nm;
        cancelled_orders          = canc;
        cache_res_data            = {mx, ac};
        exp_q.push_back({exp_to, exp_acc, 1'b0, 2'(p)});
        while (!done && k < 400) begin
            #1;
            if (k == 0) chk("req_ready", 64'(req_ready), 64'(4'b0001 << p));
            cache_res_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (cache_req_valid && !cache_req_rw) begin
                if (!idx_checked) chk("cache_index", 64'(cache_req_index), 64'({18'b0, 5'b0, cid, 4'b0}));
                idx_checked     = 1;
                cache_res_ready = (rd_n == rd_lat);
                rd_n++;
            end else if (cache_req_valid && cache_req_rw) begin
                if (!wr_seen) wd = cache_req_data;
                wr_seen         = 1;
                cache_res_ready = (wr_n == wr_lat);
                wr_n++;
            end
            if (rsp_valid) begin
                done  = 1;
                exp_r = exp_q.pop_front();
                chk("rsp_fields", 64'({rsp_timeout, rsp_accept, 1'b0, rsp_port}), 64'(exp_r));
                chk("latency", 64'(k + 1), 64'(exp_cyc));
            end else begin
                @(negedge clk);
                k++;
                if (k == 1) req_valid = '0;
            end
        end
        if (!done) begin
            chk("rsp_bound", 64'd0, 64'd1);
            void'(exp_q.pop_front());
        end
        chk("write_issued", 64'(wr_seen), 64'(exp_wr));
        if (exp_wr) chk("write_data", 64'(wd), 64'(exp_wd));
        cache_res_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_after_rsp", 64'(busy), 64'd0);
    endtask

    typedef struct {
        int          port;
        logic [4:0]  cid;
        logic [15:0] amt;
        logic        nm;
        logic [15:0] mx;
        logic [15:0] ac;
        logic [15:0] canc;
        int          rd_lat;
        int          wr_lat;
        logic        exp_acc;
        logic        exp_to;
        logic [31:0] exp_wd;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int k, grants, last_k;
        logic e_acc, e_to, e_wr;
        logic [31:0] e_wd;
        int e_cyc;

        vecs[0] = '{0, 5'd3,  16'd10,    1'b0, 16'd100,   16'd20,    16'd5,     0,   0,   1'b1, 1'b0, 32'h0064_001E, 5};
        vecs[1] = '{1, 5'd7,  16'd90,    1'b0, 16'd100,   16'd20,    16'd5,     0,   0,   1'b0, 1'b0, 32'h0,         4};
        vecs[2] = '{2, 5'd9,  16'd500,   1'b1, 16'd100,   16'd20,    16'hFFFF,  0,   0,   1'b1, 1'b0, 32'h01F4_0014, 5};
        vecs[3] = '{3, 5'd31, 16'd1,     1'b0, 16'd0,     16'd0,     16'd0,     0,   0,   1'b0, 1'b0, 32'h0,         4};
        vecs[4] = '{0, 5'd12, 16'd10,    1'b0, 16'd50,    16'd40,    16'd0,     0,   0,   1'b0, 1'b0, 32'h0,         4};
        vecs[5] = '{1, 5'd1,  16'd0,     1'b0, 16'd0,     16'd0,     16'd1,     0,   0,   1'b1, 1'b0, 32'h0,         5};
        vecs[6] = '{2, 5'd2,  16'h1000,  1'b0, 16'h8000,  16'h7000,  16'd0,     0,   0,   1'b1, 1'b0, 32'h8000_8000, 5};
        vecs[7] = '{1, 5'd4,  16'd10,    1'b0, 16'd100,   16'd20,    16'd5,     3,   2,   1'b1, 1'b0, 32'h0064_001E, 10};
        vecs[8] = '{2, 5'd5,  16'd10,    1'b0, 16'd100,   16'd20,    16'd5,     200, 0,   1'b0, 1'b1, 32'h0,         66};
        vecs[9] = '{0, 5'd6,  16'd700,   1'b1, 16'd100,   16'd20,    16'd0,     0,   200, 1'b0, 1'b1, 32'h02BC_0014, 68};

        #1;
        chk_outputs_zero("async_reset_t0");
        do_reset();

        for (int i = 0; i < 10; i++) begin
            e_wr = vecs[i].exp_acc | (vecs[i].exp_to & (vecs[i].rd_lat < TIMEOUT));
            run_txn(vecs[i].port, vecs[i].cid, vecs[i].amt, vecs[i].nm, vecs[i].mx, vecs[i].ac,
                    vecs[i].canc, vecs[i].rd_lat, vecs[i].wr_lat, 1'b0, vecs[i].exp_acc,
                    vecs[i].exp_to, e_wr, vecs[i].exp_wd, vecs[i].exp_cyc);
        end

        // All ports requesting continuously: strict rotation starting from port 0.
        do_reset();
        for (int p = 0; p < NP; p++) begin
            req_client_id[p*5 +: 5] = 5'(p);
            req_amount[p*16 +: 16]  = 16'(p + 1);
            req_new_max[p]          = 1'b1;
        end
        cache_res_data = 32'h0064_0014;
        req_valid = 4'hF;
        grants = 0; k = 0; last_k = 0;
        while (grants < 5 && k < 100) begin
            #1;
            cache_res_ready = cache_req_valid;
            if (req_ready != '0) begin
                chk("rr_onehot", 64'($onehot(req_ready)), 64'd1);
                chk("rr_order", 64'(req_ready), 64'(4'b0001 << (grants % NP)));
                if (grants > 0) chk("rr_spacing", 64'(k - last_k), 64'd5);
                last_k = k;
                grants++;
            end
            @(negedge clk);
            k++;
        end
        chk("rr_grant_count", 64'(grants), 64'd5);
        req_valid = '0;
        k = 0;
        while (k < 20) begin
            #1;
            cache_res_ready = cache_req_valid;
            if (!busy) break;
            @(negedge clk);
            k++;
        end
        chk("rr_drain", 64'(busy), 64'd0);

        // Reset while a write is outstanding; ports 0 and 3 pending across the reset.
        do_reset();
        req_client_id[2*5 +: 5] = 5'd17;
        req_amount[2*16 +: 16]  = 16'h0033;
        req_new_max[2]          = 1'b1;
        cache_res_data          = 32'h0064_0014;
        req_valid               = 4'b0100;
        k = 0;
        while (k < 20) begin
            #1;
            if (cache_req_valid && cache_req_rw) break;
            cache_res_ready = cache_req_valid;
            @(negedge clk);
            k++;
            if (k == 1) req_valid = '0;
        end
        chk("reach_wr", 64'(cache_req_valid && cache_req_rw), 64'd1);
        cache_res_ready = 1'b0;
        req_valid       = 4'b1001;
        #1 rst = 1'b1;
        #1;
        chk_outputs_zero("midwr_reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_reset_grant", 64'(req_ready), 64'(4'b0001));
        do_reset();

        // Randomized traffic with cache_res_ready noise outside RD/WR.
        for (int i = 0; i < 40; i++) begin
            int p, rl, wl;
            logic [4:0]  cid;
            logic [15:0] amt, mx, ac, canc;
            logic        nm;
            p    = $urandom_range(0, NP - 1);
            cid  = 5'($urandom_range(0, 31));
            amt  = 16'($urandom);
            mx   = 16'($urandom);
            ac   = 16'($urandom);
            canc = 16'($urandom);
            nm   = ($urandom_range(0, 3) == 0);
            rl   = $urandom_range(0, 3);
            wl   = $urandom_range(0, 3);
            ref_model(mx, ac, canc, amt, nm, rl, wl, e_acc, e_to, e_wr, e_wd, e_cyc);
            run_txn(p, cid, amt, nm, mx, ac, canc, rl, wl, 1'b1, e_acc, e_to, e_wr, e_wd, e_cyc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
